// File: rtl/fibo_result_display.sv
// Converts the 32-bit Fibonacci result to packed BCD using a sequential double-dabble engine
// and drives eight active-low seven-segment digits with optional leading-zero blanking.
module fibo_result_display #(
    parameter bit BLANK_ZEROS  = 1'b1,
    parameter bit AUTO_REFRESH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd,
    output logic        overflow,
    output logic [55:0] segments
);

    localparam int unsigned VALUE_W    = 32;
    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned SEG_DIGITS = 8;
    localparam int unsigned CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VALUE_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [VALUE_W-1:0]   shift_q, shift_next;
    logic [VALUE_W-1:0]   last_q, last_next;
    logic [BCD_W-1:0]     scratch_q, scratch_next;
    logic [BCD_W-1:0]     adj;
    logic [CNT_W-1:0]     cnt_q, cnt_next;
    logic [BCD_W-1:0]     bcd_next;
    logic                 ovf_next;
    logic                 done_next;
    logic                 busy_next;
    logic                 start_c;

    assign start_c = load || (AUTO_REFRESH && (value != last_q));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            last_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_q   <= shift_next;
            last_q    <= last_next;
            scratch_q <= scratch_next;
            cnt_q     <= cnt_next;
            bcd       <= bcd_next;
            overflow  <= ovf_next;
            done      <= done_next;
            busy      <= busy_next;
        end
    end

    // Next-state and double-dabble step
    always_comb begin
        state_next   = state;
        shift_next   = shift_q;
        last_next    = last_q;
        scratch_next = scratch_q;
        cnt_next     = cnt_q;
        bcd_next     = bcd;
        ovf_next     = overflow;
        done_next    = 1'b0;
        busy_next    = busy;
        adj          = scratch_q;

        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state)
            IDLE: begin
                if (start_c) begin
                    state_next   = SHIFT;
                    shift_next   = value;
                    last_next    = value;
                    scratch_next = '0;
                    cnt_next     = '0;
                    busy_next    = 1'b1;
                end
            end
            SHIFT: begin
                scratch_next = {adj[BCD_W-2:0], shift_q[VALUE_W-1]};
                shift_next   = {shift_q[VALUE_W-2:0], 1'b0};
                cnt_next     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_next = IDLE;
                    bcd_next   = scratch_next;
                    ovf_next   = |scratch_next[BCD_W-1:4*SEG_DIGITS];
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [3:0] digit;
    logic       zero_run;
    logic       blank;

    // Segment decode; zero_run tracks whether every digit from 7 down to k is zero
    always_comb begin
        segments = '1;
        digit    = '0;
        zero_run = 1'b1;
        blank    = 1'b0;
        for (int k = int'(SEG_DIGITS) - 1; k >= 0; k--) begin
            digit    = bcd[4*k +: 4];
            zero_run = zero_run && (digit == 4'd0);
            blank    = BLANK_ZEROS && (k != 0) && zero_run && !overflow;
            segments[7*k +: 7] = blank ? 7'h7F : seg7(digit);
        end
    end

endmodule

// File: tb/tb_fibo_result_display.sv
// Directed bench for fibo_result_display: vector table for conversions plus
// hand-written sequences for request handling, auto refresh and mid-conversion reset.
module tb_fibo_result_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic        overflow;
    logic [55:0] segments;

    int errors = 0;
    int checks = 0;

    fibo_result_display #(
        .BLANK_ZEROS (1'b1),
        .AUTO_REFRESH(1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .overflow(overflow),
        .segments(segments)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [55:0] SEG_RESET = {BL, BL, BL, BL, BL, BL, BL, S0};

    typedef struct {
        logic [31:0] value;
        logic [39:0] bcd;
        logic        ovf;
        logic [55:0] seg;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive value with a one-cycle load; returns at the falling edge after the start edge
    task automatic start_load(input logic [31:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Waits (bounded) for the done pulse, counting busy cycles seen on the way
    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) cycles++;
            @(negedge clk);
        end
    endtask

    task automatic quiet(input int n, output int dones, output int busys);
        dones = 0;
        busys = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busys++;
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        int nd;
        int nb;

        vecs[0] = '{32'd55,         40'h0000000055, 1'b0, {BL, BL, BL, BL, BL, BL, S5, S5}};
        vecs[1] = '{32'hFFFFFFFF,   40'h4294967295, 1'b1, {S9, S4, S9, S6, S7, S2, S9, S5}};
        vecs[2] = '{32'd0,          40'h0000000000, 1'b0, SEG_RESET};
        vecs[3] = '{32'd100000000,  40'h0100000000, 1'b1, {S0, S0, S0, S0, S0, S0, S0, S0}};
        vecs[4] = '{32'd99999999,   40'h0099999999, 1'b0, {S9, S9, S9, S9, S9, S9, S9, S9}};
        vecs[5] = '{32'd1000,       40'h0000001000, 1'b0, {BL, BL, BL, BL, S1, S0, S0, S0}};
        vecs[6] = '{32'd12345678,   40'h0012345678, 1'b0, {S1, S2, S3, S4, S5, S6, S7, S8}};

        reset = 1'b1;
        value = 32'd0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_seg", 64'(segments), 64'(SEG_RESET));
        reset = 1'b0;
        quiet(5, nd, nb);
        check("reset_no_auto_start", 64'(nb + nd), 64'd0);

        for (int i = 0; i < 7; i++) begin
            start_load(vecs[i].value);
            wait_done(cyc, seen);
            check($sformatf("vec%0d_done_seen", i), 64'(seen), 64'd1);
            check($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'd32);
            check($sformatf("vec%0d_bcd", i), 64'(bcd), 64'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_seg", i), 64'(segments), 64'(vecs[i].seg));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_idle_after", i), 64'(busy), 64'd0);
        end

        // load during a conversion is ignored; load in the done cycle starts the next one
        start_load(32'd1234);
        repeat (4) @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done(cyc, seen);
        check("busy_load_done_seen", 64'(seen), 64'd1);
        check("busy_load_remaining", 64'(cyc), 64'd27);
        check("busy_load_bcd", 64'(bcd), 64'h1234);
        value = 32'd4321;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(cyc, seen);
        check("b2b_done_seen", 64'(seen), 64'd1);
        check("b2b_busy_cycles", 64'(cyc), 64'd32);
        check("b2b_bcd", 64'(bcd), 64'h4321);
        quiet(40, nd, nb);
        check("b2b_no_extra_done", 64'(nd), 64'd0);

        // auto refresh on value change, with a change during busy picked up afterwards
        start_load(32'd0);
        wait_done(cyc, seen);
        check("auto_zero_bcd", 64'(bcd), 64'd0);
        @(negedge clk);
        value = 32'd6765;
        @(negedge clk);
        check("auto_start_busy", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        value = 32'd10946;
        wait_done(cyc, seen);
        check("auto_first_seen", 64'(seen), 64'd1);
        check("auto_first_bcd", 64'(bcd), 64'h6765);
        @(negedge clk);
        check("auto_second_busy", 64'(busy), 64'd1);
        wait_done(cyc, seen);
        check("auto_second_seen", 64'(seen), 64'd1);
        check("auto_second_cycles", 64'(cyc), 64'd32);
        check("auto_second_bcd", 64'(bcd), 64'h10946);
        check("auto_second_seg", 64'(segments), 64'({BL, BL, BL, S1, S0, S9, S4, S6}));
        quiet(40, nd, nb);
        check("auto_held_no_done", 64'(nd + nb), 64'd0);

        // reset asserted mid-conversion
        start_load(32'd987);
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_bcd", 64'(bcd), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        check("midrst_seg", 64'(segments), 64'(SEG_RESET));
        value = 32'd0;
        reset = 1'b0;
        quiet(40, nd, nb);
        check("midrst_no_done", 64'(nd), 64'd0);
        check("midrst_idle", 64'(nb), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
